// File: rtl/bus_cycle_master_if.sv
// Request/response handshake plus the bus control and address lines of
// bus_cycle_master. Data is bidirectional and is kept as a separate inout
// port on the master.
//   master modport: seen from bus_cycle_master (takes requests, drives the bus)
//   slave modport : seen from the requesting side (issues requests, sees the bus)
interface bus_cycle_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_iom;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        ALE;
  logic        IOM;
  logic        CS;
  logic        RD;
  logic        WR;
  logic [19:0] Address;

  modport master (
    input  req_valid, req_write, req_iom, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output ALE, IOM, CS, RD, WR, Address
  );

  modport slave (
    output req_valid, req_write, req_iom, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  ALE, IOM, CS, RD, WR, Address
  );
endinterface

// File: rtl/bus_cycle_master.sv
// Turns one valid/ready request at a time into a four-state bus cycle
// (T1 address/ALE, T2-T3 strobe, T4 recovery) on a 20-bit address / 8-bit data
// bus, then returns a one-cycle response.
// Ports:
//   CLK      clock, all state changes on posedge
//   RESET_N  asynchronous active-low reset
//   bus      request/response handshake and bus control/address (master modport)
//   Data     bidirectional data bus; driven only in T2-T3 of a write
module bus_cycle_master #(
  parameter logic [19:0] CS_BASE      = 20'h00000,
  parameter int unsigned CS_SIZE_LOG2 = 20,
  parameter logic        CS_IOM       = 1'b0,
  parameter int unsigned GAP          = 0
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  bus_cycle_master_if.master    bus,
  inout  wire  [7:0]            Data
);

  typedef enum logic [2:0] {StIdle, StT1, StT2, StT3, StT4, StGapw} state_e;

  state_e      state_q;
  logic        write_q;
  logic        hit_q;
  logic [7:0]  wdata_q;
  logic        data_oe_q;
  logic [3:0]  gap_cnt_q;

  logic        accept;
  logic        hit;

  always_comb begin
    accept = bus.req_valid && bus.req_ready;
    // A shift by 20 leaves zero on both sides, so the full-window case hits.
    hit    = (bus.req_iom == CS_IOM) &&
             ((bus.req_addr >> CS_SIZE_LOG2) == (CS_BASE >> CS_SIZE_LOG2));
  end

  assign Data = data_oe_q ? wdata_q : 8'hzz;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= StIdle;
      write_q       <= 1'b0;
      hit_q         <= 1'b0;
      wdata_q       <= 8'h00;
      data_oe_q     <= 1'b0;
      gap_cnt_q     <= 4'd0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 8'h00;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.ALE       <= 1'b0;
      bus.IOM       <= 1'b0;
      bus.CS        <= 1'b0;
      bus.RD        <= 1'b1;
      bus.WR        <= 1'b1;
      bus.Address   <= 20'h00000;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
        StT1: begin
          state_q   <= StT2;
          bus.ALE   <= 1'b0;
          bus.RD    <= write_q;
          bus.WR    <= !write_q;
          data_oe_q <= write_q;
        end
        StT2: state_q <= StT3;
        StT3: begin
          state_q       <= StT4;
          bus.RD        <= 1'b1;
          bus.WR        <= 1'b1;
          bus.CS        <= 1'b0;
          data_oe_q     <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= !hit_q;
          // Data is sampled at the edge that ends T3, while RD is still low.
          bus.rsp_rdata <= write_q ? 8'h00 : (hit_q ? Data : 8'hFF);
          bus.req_ready <= (GAP == 0);
        end
        StT4: begin
          if (GAP > 0) begin
            state_q       <= StGapw;
            gap_cnt_q     <= 4'(GAP - 1);
            bus.req_ready <= 1'b0;
          end else begin
            state_q       <= StIdle;
            bus.busy      <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        StGapw: begin
          if (gap_cnt_q == 4'd0) begin
            state_q       <= StIdle;
            bus.busy      <= 1'b0;
            bus.req_ready <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Acceptance (IDLE, or T4 when GAP is 0) overrides the per-state update.
      if (accept) begin
        state_q       <= StT1;
        write_q       <= bus.req_write;
        hit_q         <= hit;
        wdata_q       <= bus.req_wdata;
        bus.ALE       <= 1'b1;
        bus.Address   <= bus.req_addr;
        bus.IOM       <= bus.req_iom;
        bus.CS        <= hit;
        bus.busy      <= 1'b1;
        bus.req_ready <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bus_cycle_master.md
Name: bus_cycle_master

Overview:
Bus master that turns a single-outstanding valid/ready request from the CPU side into one 4-state bus cycle (T1–T4). It drives ALE, IOM, CS, RD, WR, Address and Data to the memory/IO slave directly downstream of it on the shared 20-bit address / 8-bit data bus. It captures read data and returns a one-cycle response.

Parameters:
CS_BASE, 20'h00000, base of decoded window.
CS_SIZE_LOG2, 20, window size is 2**CS_SIZE_LOG2 bytes; 20 means the whole 1 MB.
CS_IOM, 1'b0, IOM value that selects the slave (0 = memory space, 1 = IO space).
GAP, 0, idle cycles inserted after T4 before the next T1 (0..15).

Ports:
CLK  in  1  clock, all state changes on posedge.
RESET_N  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted at a posedge when req_valid && req_ready.
req_write  in  1  1 = write, 0 = read.
req_iom  in  1  space select, driven onto IOM.
req_addr  in  20  byte address.
req_wdata  in  8  write data.
rsp_valid  out  1  one-cycle response pulse.
rsp_rdata  out  8  read data; 8'h00 for writes.
rsp_err  out  1  decode miss.
busy  out  1  state != IDLE.
ALE  out  1  address latch enable, active high.
IOM  out  1  space select.
CS  out  1  slave chip select, active high.
RD  out  1  read strobe, active low.
WR  out  1  write strobe, active low.
Address  out  20  bus address.
Data  inout  8  bidirectional data bus.

Behaviour:
- Reset, asynchronous, taking effect immediately:
  - state = IDLE.
  - ALE = 0, CS = 0, IOM = 0, RD = 1, WR = 1, Address = 0, Data = Z.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - req_ready = 0 while RESET_N is low.
  - A cycle in flight is abandoned with no response.
- States: IDLE, T1, T2, T3, T4, GAPW.
- Request capture: on acceptance, req_write, req_iom, req_addr and req_wdata are registered. Bus outputs come only from these registers, never from req_* directly.
- Decode: hit = (req_iom == CS_IOM) && (CS_SIZE_LOG2 == 20 || addr[19:CS_SIZE_LOG2] == CS_BASE[19:CS_SIZE_LOG2]). Evaluated at acceptance and registered.
- req_ready = 1 in IDLE, and also in T4 when GAP == 0. Acceptance moves the FSM to T1.
- T1: ALE = 1, Address = addr, IOM = iom, CS = hit.
- T2: ALE = 0; Address, IOM and CS held. RD = 0 for a read, WR = 0 for a write. For a write, Data is driven with wdata.
- T3: RD/WR held low; Address, IOM, CS and write Data held.
  - The slave transfers during this cycle.
  - For a read, Data is sampled at the posedge ending T3: rsp_rdata = hit ? Data : 8'hFF.
- T4: RD = 1, WR = 1, CS = 0, Data = Z. Address holds its last value.
  - rsp_valid = 1 for exactly this cycle; rsp_err = !hit; rsp_rdata is valid this cycle.
  - Next state: T1 if a request is accepted this cycle (GAP == 0), else GAPW if GAP > 0, else IDLE.
- GAPW: counts GAP cycles with all strobes inactive, then goes to IDLE.
- Timing and throughput:
  - Latency from acceptance edge to rsp_valid is 4 cycles.
  - Back-to-back throughput with GAP = 0 is one transaction per 4 cycles.
  - With GAP = 0, ALE of the next cycle lands in the cycle after T4, when the slave has returned to idle.
- Decode miss: the cycle still runs (ALE, RD/WR toggle), but CS stays 0. A write has no effect; a read returns 8'hFF with rsp_err = 1.
- Bus discipline:
  - Data is driven only in T2–T3 of a write and never while RD = 0.
  - RD and WR are never low together.
  - ALE and RD/WR are never active in the same cycle.
- A request that is not accepted must stay stable; the block does not check this.

Test Plan:
- Write 0xA5 to mem 0x12345 with the slave attached → ALE high one cycle, WR low for T2–T3, Data = 0xA5 in T2–T3 and Z otherwise; rsp_valid 4 cycles after accept with rsp_err = 0; the slave's mem[0x12345] = 0xA5.
- Read 0x12345 → RD low for T2–T3, Data never driven by the master; rsp_rdata = 0xA5 in T4; Data = Z in T4.
- Three back-to-back requests with GAP = 0 (write 0x00001 = 0x3C, read 0x00001, read 0xFFFFF) → rsp_valid on cycles 4, 8, 12 after the first accept; the first read returns 0x3C.
- CS_SIZE_LOG2 = 16, CS_BASE = 20'h20000, read 0x30000 → CS stays 0, rsp_rdata = 0xFF, rsp_err = 1; a write to the same address leaves slave memory unchanged.
- RESET_N pulsed low during T2 of a write → RD = WR = 1, Data = Z and req_ready = 0 immediately; no rsp_valid; the slave memory location is unchanged; a request after reset completes normally.
- GAP = 2, two queued requests → T4, GAPW, GAPW, IDLE, T1; rsp_valid spacing of 7 cycles; req_ready low during GAPW.
